// File: rtl/conv1d_seq.sv
// conv1d_seq: sliding-window sequencer for the 1D convolution MAC datapath.
// Define CONV1D_STRIDE_EN to add a run-time input stride port.
module conv1d_seq #(
    parameter int KSIZE   = 3,
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
`ifdef CONV1D_STRIDE_EN
    input  logic [LEN_W-1:0] stride,
`endif
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] smp_addr,
    output logic [LEN_W-1:0] k_addr,
    output logic             mac_en,
    output logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LEN_W-1:0] out_idx
);

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, EMIT, DONE} state_t;

    localparam int               DW         = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [LEN_W-1:0] TAP_LAST   = LEN_W'(KSIZE - 1);
    localparam logic [LEN_W+1:0] KSIZE_X    = (LEN_W + 2)'(KSIZE);
    localparam logic [DW-1:0]    DRAIN_INIT = DW'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] win;
    logic [LEN_W-1:0] base;
    logic [LEN_W-1:0] tap;
    logic [LEN_W-1:0] step;
    logic [DW-1:0]    drain_cnt;
    logic             len_ok;
    logic             accept;
    logic             last_win;

    assign len_ok = {2'b00, len} >= KSIZE_X;
    assign accept = (state == IDLE) && start && len_ok;

    // The current window is the last one when the next base would push the
    // window past the final sample; this replaces a divider for nout.
    assign last_win = ({2'b00, base} + {2'b00, step} + KSIZE_X) > {2'b00, len_q};

`ifdef CONV1D_STRIDE_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            step <= LEN_W'(1);
        else if (accept)
            step <= (stride == '0) ? LEN_W'(1) : stride;
    end
`else
    assign step = LEN_W'(1);
`endif

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every branch sees pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            mac_en    <= 1'b0;
            acc_clr   <= 1'b0;
            out_valid <= 1'b0;
            smp_addr  <= '0;
            k_addr    <= '0;
            out_idx   <= '0;
            len_q     <= '0;
            win       <= '0;
            base      <= '0;
            tap       <= '0;
            drain_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        err      <= 1'b0;
                        busy     <= 1'b1;
                        len_q    <= len;
                        win      <= '0;
                        base     <= '0;
                        tap      <= '0;
                        mac_en   <= 1'b1;
                        acc_clr  <= 1'b1;
                        smp_addr <= '0;
                        k_addr   <= '0;
                        state    <= RUN;
                    end else if (start) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                RUN: begin
                    if (tap == TAP_LAST) begin
                        mac_en  <= 1'b0;
                        acc_clr <= 1'b0;
                        if (MAC_LAT > 0) begin
                            drain_cnt <= DRAIN_INIT;
                            state     <= DRAIN;
                        end else begin
                            out_valid <= 1'b1;
                            out_idx   <= win;
                            state     <= EMIT;
                        end
                    end else begin
                        tap      <= tap + 1'b1;
                        smp_addr <= base + tap + 1'b1;
                        k_addr   <= tap + 1'b1;
                        acc_clr  <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        out_valid <= 1'b1;
                        out_idx   <= win;
                        state     <= EMIT;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (last_win) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            win      <= win + 1'b1;
                            base     <= base + step;
                            tap      <= '0;
                            mac_en   <= 1'b1;
                            acc_clr  <= 1'b1;
                            smp_addr <= base + step;
                            k_addr   <= '0;
                            state    <= RUN;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv1d_seq.sv
// Scoreboard bench for conv1d_seq: stimulus pushes expected taps/outputs/done
// events into queues, a negedge monitor pops and compares them.
module tb_conv1d_seq;

    localparam int KSIZE   = 3;
    localparam int LEN_W   = 8;
    localparam int MAC_LAT = 1;

    typedef struct packed {
        logic [LEN_W-1:0] smp;
        logic [LEN_W-1:0] k;
        logic             clr;
    } tap_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
`ifdef CONV1D_STRIDE_EN
    logic [LEN_W-1:0] stride = 8'd1;
`endif
    logic             busy, done, err, mac_en, acc_clr, out_valid;
    logic             out_ready = 1'b1;
    logic [LEN_W-1:0] smp_addr, k_addr, out_idx;

    conv1d_seq #(.KSIZE(KSIZE), .LEN_W(LEN_W), .MAC_LAT(MAC_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
`ifdef CONV1D_STRIDE_EN
        .stride    (stride),
`endif
        .busy      (busy),
        .done      (done),
        .err       (err),
        .smp_addr  (smp_addr),
        .k_addr    (k_addr),
        .mac_en    (mac_en),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    tap_t             tap_q[$];
    logic [LEN_W-1:0] out_q[$];
    logic             err_q[$];

    logic             mon_en = 1'b0;
    int               done_cnt = 0;
    int               done_cyc = 0;
    int               start_cyc = 0;
    logic             stall_prev = 1'b0;
    logic [LEN_W-1:0] prev_idx = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected traffic for one window: KSIZE taps from base, then output idx.
    task automatic push_window(input int base, input int idx);
        tap_t e;
        for (int t = 0; t < KSIZE; t++) begin
            e.smp = LEN_W'(base + t);
            e.k   = LEN_W'(t);
            e.clr = (t == 0);
            tap_q.push_back(e);
        end
        out_q.push_back(LEN_W'(idx));
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (stall_prev) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_idx", 32'(out_idx), 32'(prev_idx));
                check("stall_mac_en", 32'(mac_en), 32'd0);
            end
            if (mac_en) begin
                if (tap_q.size() == 0) begin
                    check("unexpected_mac_en", 32'(mac_en), 32'd0);
                end else begin
                    tap_t e;
                    e = tap_q.pop_front();
                    check("smp_addr", 32'(smp_addr), 32'(e.smp));
                    check("k_addr", 32'(k_addr), 32'(e.k));
                    check("acc_clr", 32'(acc_clr), 32'(e.clr));
                end
            end
            if (out_valid && out_ready) begin
                if (out_q.size() == 0)
                    check("unexpected_out_valid", 32'(out_valid), 32'd0);
                else
                    check("out_idx", 32'(out_idx), 32'(out_q.pop_front()));
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (err_q.size() == 0)
                    check("unexpected_done", 32'(done), 32'd0);
                else
                    check("done_err", 32'(err), 32'(err_q.pop_front()));
            end
            stall_prev = out_valid && !out_ready;
            prev_idx   = out_idx;
        end
    end

    task automatic issue_start(input int l);
        @(posedge clk); #1;
        start = 1'b1;
        len   = LEN_W'(l);
        @(posedge clk); #1;
        start     = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_cnt > d0) break;
        end
        #1;
        check("done_seen", 32'(done_cnt > d0), 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_mac_en"}, 32'(mac_en), 32'd0);
        check({tag, "_acc_clr"}, 32'(acc_clr), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_smp_addr"}, 32'(smp_addr), 32'd0);
        check({tag, "_k_addr"}, 32'(k_addr), 32'd0);
        check({tag, "_out_idx"}, 32'(out_idx), 32'd0);
    endtask

    initial begin
        #1;
        check_idle_outputs("reset");
        @(posedge clk); #1;
        reset  = 1'b1;
        mon_en = 1'b1;

        // len=5: windows at 0,1,2; start pulsed mid-run must be ignored.
        push_window(0, 0);
        push_window(1, 1);
        push_window(2, 2);
        err_q.push_back(1'b0);
        issue_start(5);
        repeat (3) @(posedge clk);
        #1;
        check("busy_in_run", 32'(busy), 32'd1);
        start = 1'b1;
        len   = 8'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(100);
        check("run_len5_cycles", 32'(done_cyc - start_cyc), 32'd15);
        check("busy_after_done", 32'(busy), 32'd0);

        // len=2 is rejected: done right after start, err held afterwards.
        err_q.push_back(1'b1);
        issue_start(2);
        wait_done(20);
        check("reject_latency", 32'(done_cyc - start_cyc), 32'd0);
        check("err_held", 32'(err), 32'd1);

        // len=3: a single window; err clears on this accepted start.
        push_window(0, 0);
        err_q.push_back(1'b0);
        issue_start(3);
        wait_done(50);
        check("err_cleared", 32'(err), 32'd0);

        // len=6 with the consumer stalling 4 cycles on output 1.
        push_window(0, 0);
        push_window(1, 1);
        push_window(2, 2);
        push_window(3, 3);
        err_q.push_back(1'b0);
        issue_start(6);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(posedge clk); #1;
                if (out_valid && out_idx == 8'd1) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("stall_target_seen", 32'(seen), 32'd1);
        end
        out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_done(100);

        // Reset in the middle of RUN abandons the run at once.
        push_window(0, 0);
        issue_start(6);
        @(posedge clk); #1;
        check("mid_run_mac_en", 32'(mac_en), 32'd1);
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        tap_q.delete();
        out_q.delete();
        err_q.delete();
        stall_prev = 1'b0;
        @(posedge clk); #1;
        check("held_in_reset", 32'(busy), 32'd0);
        reset  = 1'b1;
        mon_en = 1'b1;

        // len=4 after reset: windows at 0,1.
        push_window(0, 0);
        push_window(1, 1);
        err_q.push_back(1'b0);
        issue_start(4);
        wait_done(60);

`ifdef CONV1D_STRIDE_EN
        // stride=2, len=7: window bases 0,2,4.
        stride = 8'd2;
        push_window(0, 0);
        push_window(2, 1);
        push_window(4, 2);
        err_q.push_back(1'b0);
        issue_start(7);
        wait_done(100);
        stride = 8'd1;
`endif

        repeat (3) @(posedge clk);
        #1;
        check("taps_drained", 32'(tap_q.size()), 32'd0);
        check("outputs_drained", 32'(out_q.size()), 32'd0);
        check("dones_drained", 32'(err_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
